// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and helpers for the PS/2 keyboard receiver
package ps2_pkg;

    typedef logic [1:0] ps2_state_t;

    localparam ps2_state_t ST_IDLE   = 2'd0;
    localparam ps2_state_t ST_DATA   = 2'd1;
    localparam ps2_state_t ST_PARITY = 2'd2;
    localparam ps2_state_t ST_STOP   = 2'd3;

    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
    localparam logic [7:0] PS2_KEY_SPACE = 8'h29;
    localparam logic [7:0] PS2_KEY_ESC   = 8'h76;
    localparam logic [7:0] PS2_KEY_ENTER = 8'h5A;

    // A PS/2 frame carries odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-FF synchronizer, run-length glitch filter and fall pulse for one PS/2 pin
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_pixel,
    input  logic resetn,
    input  logic pin,
    output logic sync,
    output logic level,
    output logic fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          meta;
    logic [CW-1:0] run_cnt;

    // The bus idles high, so the pipeline resets high to avoid a phantom fall.
    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            meta    <= 1'b1;
            sync    <= 1'b1;
            level   <= 1'b1;
            run_cnt <= '0;
            fall    <= 1'b0;
        end else begin
            meta <= pin;
            sync <= meta;
            fall <= 1'b0;
            if (sync == level) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
                level   <= sync;
                run_cnt <= '0;
                fall    <= level;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_rx.sv
// rtl/ps2_key_rx.sv - receive-only PS/2 set-2 keyboard decoder with flap/reset key level flags
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int         CLK_HZ     = 25_200_000,
    parameter int         FILTER_LEN = 8,
    parameter int         TIMEOUT_US = 2000,
    parameter logic [7:0] FLAP_CODE  = PS2_KEY_SPACE,
    parameter logic [7:0] RESET_CODE = PS2_KEY_ESC
) (
    input  logic       clk_pixel,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       scan_break,
    output logic       scan_ext,
    output logic       frame_err,
    output logic       flap_held,
    output logic       reset_held
);

    localparam int         TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_US / 1000;
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYC - 1);

    logic clk_fall;
    logic clk_sync_unused;
    logic clk_level_unused;
    logic dat_sync;
    logic dat_level_unused;
    logic dat_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk_pixel (clk_pixel),
        .resetn    (resetn),
        .pin       (ps2_clk),
        .sync      (clk_sync_unused),
        .level     (clk_level_unused),
        .fall      (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(1)) u_dat_sync (
        .clk_pixel (clk_pixel),
        .resetn    (resetn),
        .pin       (ps2_dat),
        .sync      (dat_sync),
        .level     (dat_level_unused),
        .fall      (dat_fall_unused)
    );

    ps2_state_t  state;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        par_bit;
    logic [15:0] tmo_cnt;
    logic        ext_flag;
    logic        brk_flag;

    logic frame_good;
    logic is_pfx_ext;
    logic is_pfx_brk;

    always_comb begin
        frame_good = dat_sync && odd_parity_ok(shreg, par_bit);
        is_pfx_ext = (shreg == PS2_PFX_EXT);
        is_pfx_brk = (shreg == PS2_PFX_BRK);
    end

    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            tmo_cnt    <= '0;
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            scan_code  <= '0;
            scan_valid <= 1'b0;
            scan_break <= 1'b0;
            scan_ext   <= 1'b0;
            frame_err  <= 1'b0;
            flap_held  <= 1'b0;
            reset_held <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (clk_fall) begin
                // A fall always beats a coincident timeout: the counter restarts here.
                tmo_cnt <= '0;
                case (state)
                    ST_IDLE: begin
                        if (!dat_sync) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {dat_sync, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_bit <= dat_sync;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (!frame_good) begin
                            frame_err <= 1'b1;
                            ext_flag  <= 1'b0;
                            brk_flag  <= 1'b0;
                        end else if (is_pfx_ext) begin
                            ext_flag <= 1'b1;
                        end else if (is_pfx_brk) begin
                            brk_flag <= 1'b1;
                        end else begin
                            scan_valid <= 1'b1;
                            scan_code  <= shreg;
                            scan_break <= brk_flag;
                            scan_ext   <= ext_flag;
                            ext_flag   <= 1'b0;
                            brk_flag   <= 1'b0;
                            // Extended keys share base codes with the tracked keys; ignore them.
                            if (!ext_flag) begin
                                if (shreg == FLAP_CODE) begin
                                    flap_held <= ~brk_flag;
                                end
                                if (shreg == RESET_CODE) begin
                                    reset_held <= ~brk_flag;
                                end
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state == ST_IDLE) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TMO_LAST) begin
                state     <= ST_IDLE;
                tmo_cnt   <= '0;
                frame_err <= 1'b1;
                ext_flag  <= 1'b0;
                brk_flag  <= 1'b0;
            end else begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb/tb_ps2_key_rx.sv - randomized PS/2 keyboard stimulus against a frame-level event model
module tb_ps2_key_rx;

    localparam int FL   = 8;
    localparam int LAT  = FL + 2;
    localparam int TMO  = 25_200_000 / 1000 * 2000 / 1000;
    localparam int HALF = 24;

    logic       clk_pixel = 1'b0;
    logic       resetn    = 1'b0;
    logic       ps2_clk   = 1'b1;
    logic       ps2_dat   = 1'b1;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       scan_break;
    logic       scan_ext;
    logic       frame_err;
    logic       flap_held;
    logic       reset_held;

    ps2_key_rx dut (
        .clk_pixel  (clk_pixel),
        .resetn     (resetn),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .scan_break (scan_break),
        .scan_ext   (scan_ext),
        .frame_err  (frame_err),
        .flap_held  (flap_held),
        .reset_held (reset_held)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct {
        int         cyc;
        bit         err;
        logic [7:0] code;
        bit         brk;
        bit         ext;
        bit         flap;
        bit         rst;
    } ev_t;

    ev_t evq[$];
    ev_t cur;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  last_k = 0;
    bit  m_ext = 0, m_brk = 0, m_flap = 0, m_rst = 0;
    bit  exp_flap = 0, exp_rst = 0;
    bit  ev_v, ev_e;

    int         n_valid = 0, n_err = 0, err_cyc = 0;
    logic [7:0] last_code = '0;
    logic       last_brk = 1'b0, last_ext = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk_pixel) cyc++;

    always @(negedge clk_pixel) begin
        if (scan_valid) begin
            n_valid++;
            last_code = scan_code;
            last_brk  = scan_break;
            last_ext  = scan_ext;
        end
        if (frame_err) begin
            n_err++;
            err_cyc = cyc;
        end
    end

    // Per-cycle comparison against the frame-level model.
    always @(negedge clk_pixel) begin
        if (!resetn) begin
            evq.delete();
            exp_flap = 0;
            exp_rst  = 0;
            chk("reset scan_valid", scan_valid, 0);
            chk("reset frame_err", frame_err, 0);
            chk("reset scan_code", scan_code, 0);
            chk("reset flap_held", flap_held, 0);
            chk("reset reset_held", reset_held, 0);
        end else begin
            ev_v = 0;
            ev_e = 0;
            if (evq.size() > 0 && evq[0].cyc < cyc) begin
                chk("event overdue", evq[0].cyc, cyc);
                void'(evq.pop_front());
            end
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                cur = evq.pop_front();
                if (cur.err) ev_e = 1;
                else         ev_v = 1;
            end
            chk("scan_valid", scan_valid, ev_v);
            chk("frame_err", frame_err, ev_e);
            if (ev_v) begin
                chk("scan_code", scan_code, cur.code);
                chk("scan_break", scan_break, cur.brk);
                chk("scan_ext", scan_ext, cur.ext);
                exp_flap = cur.flap;
                exp_rst  = cur.rst;
            end
            chk("flap_held", flap_held, exp_flap);
            chk("reset_held", reset_held, exp_rst);
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk_pixel);
    endtask

    task automatic model_frame(input logic [7:0] b, input bit bad, input bit full, input int k);
        ev_t ev;
        ev.code = b;
        ev.brk  = m_brk;
        ev.ext  = m_ext;
        ev.err  = 0;
        ev.cyc  = k + LAT;
        if (!full) begin
            ev.err = 1;
            ev.cyc = k + LAT + TMO;
            m_ext = 0;
            m_brk = 0;
        end else if (bad) begin
            ev.err = 1;
            m_ext = 0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
            return;
        end else if (b == 8'hF0) begin
            m_brk = 1;
            return;
        end else begin
            if (!m_ext && b == 8'h29) m_flap = !m_brk;
            if (!m_ext && b == 8'h76) m_rst  = !m_brk;
            m_ext = 0;
            m_brk = 0;
        end
        ev.flap = m_flap;
        ev.rst  = m_rst;
        evq.push_back(ev);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input int glitch_bit);
        logic [10:0] bits;
        int k;
        bits = {~bad_stop, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            wait_n(HALF / 2);
            ps2_dat = bits[i];
            if (i == glitch_bit) begin
                ps2_clk = 1'b0;
                wait_n(3);
                ps2_clk = 1'b1;
                wait_n(HALF / 2 - 3);
            end else begin
                wait_n(HALF / 2);
            end
            ps2_clk = 1'b0;
            k = cyc + 1;
            last_k = k;
            if (i == nbits - 1) model_frame(b, bad_par || bad_stop, nbits == 11, k);
            wait_n(HALF);
            ps2_clk = 1'b1;
        end
        wait_n(HALF / 2);
        ps2_dat = 1'b1;
        wait_n(2 * HALF);
    endtask

    task automatic stray_clock();
        ev_t ev;
        wait_n(HALF);
        ps2_clk = 1'b0;
        ev.cyc  = cyc + 1 + LAT;
        ev.err  = 1;
        ev.code = '0;
        ev.brk  = 0;
        ev.ext  = 0;
        ev.flap = m_flap;
        ev.rst  = m_rst;
        evq.push_back(ev);
        wait_n(HALF);
        ps2_clk = 1'b1;
        wait_n(2 * HALF);
    endtask

    initial begin
        repeat (150000) @(posedge clk_pixel);
        $display("FAIL watchdog: bench did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int r;
        logic [7:0] b;
        wait_n(3);
        chk("init scan_valid", scan_valid, 0);
        chk("init flap_held", flap_held, 0);
        @(posedge clk_pixel);
        #2 resetn = 1'b1;
        wait_n(20);

        send_frame(8'h29, 0, 0, 11, -1);
        chk("t1 code", last_code, 8'h29);
        chk("t1 brk", last_brk, 0);
        chk("t1 ext", last_ext, 0);
        chk("t1 flap", flap_held, 1);
        chk("t1 count", n_valid, 1);

        send_frame(8'hF0, 0, 0, 11, -1);
        send_frame(8'h29, 0, 0, 11, -1);
        chk("t2 count", n_valid, 2);
        chk("t2 brk", last_brk, 1);
        chk("t2 flap", flap_held, 0);

        send_frame(8'hE0, 0, 0, 11, -1);
        send_frame(8'h29, 0, 0, 11, -1);
        chk("t3 ext", last_ext, 1);
        chk("t3 flap", flap_held, 0);
        send_frame(8'h76, 0, 0, 11, -1);
        chk("t3 reset_held", reset_held, 1);
        chk("t3 ext clear", last_ext, 0);

        send_frame(8'h29, 1, 0, 11, -1);
        chk("t4 err count", n_err, 1);
        chk("t4 valid count", n_valid, 4);
        chk("t4 flap", flap_held, 0);
        send_frame(8'h76, 0, 0, 11, -1);
        chk("t4 next count", n_valid, 5);
        chk("t4 next code", last_code, 8'h76);

        send_frame(8'h29, 0, 0, 6, -1);
        wait_n(TMO + 50);
        chk("t5 err count", n_err, 2);
        chk("t5 timeout latency", err_cyc - last_k, LAT + 50400);
        send_frame(8'h29, 0, 0, 11, -1);
        chk("t5 recover", n_valid, 6);
        chk("t5 flap", flap_held, 1);

        send_frame(8'hF0, 0, 0, 11, 3);
        send_frame(8'h29, 0, 0, 11, 7);
        chk("t6 glitch count", n_valid, 7);
        chk("t6 glitch brk", last_brk, 1);
        chk("t6 glitch flap", flap_held, 0);

        send_frame(8'h29, 0, 0, 11, -1);
        send_frame(8'h76, 0, 0, 4, -1);
        @(posedge clk_pixel);
        #2 resetn = 1'b0;
        m_ext = 0; m_brk = 0; m_flap = 0; m_rst = 0;
        wait_n(2);
        chk("rst flap", flap_held, 0);
        chk("rst reset_held", reset_held, 0);
        chk("rst code", scan_code, 0);
        @(posedge clk_pixel);
        #2 resetn = 1'b1;
        wait_n(2 * LAT);
        chk("rst no valid", n_valid, 8);

        for (int it = 0; it < 25; it++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1: b = 8'hE0;
                2:    b = 8'hF0;
                3, 4: b = 8'h29;
                5, 6: b = 8'h76;
                default: b = 8'($urandom);
            endcase
            if (!m_ext && !m_brk && $urandom_range(0, 14) == 0) stray_clock();
            send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, 11,
                       ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 10)) : -1);
        end

        for (int i = 0; i < 1000 && evq.size() > 0; i++) @(negedge clk_pixel);
        chk("queue drained", evq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
